// File: rtl/music_pkg.sv
// Shared widths, song map and sequencer state encoding for the music player.
// The song boundaries must agree with the contents loaded into music_rom.
package music_pkg;

  localparam int ADDR_W = 8;
  localparam int NOTE_W = 5;

  localparam int S0_START = 0;
  localparam int S0_END   = 47;
  localparam int S1_START = 48;
  localparam int S1_END   = 83;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/music_sequencer_if.sv
// Control, ROM and note-output bundle between the player controller and the sequencer.
// The slave side is the sequencer; the master side is whoever drives play/stop and the ROM.
interface music_sequencer_if;
  import music_pkg::*;

  logic              play;
  logic              stop;
  logic              song_sel;
  logic [NOTE_W-1:0] rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W-1:0] note;
  logic              playing;
  logic              song_done;

  modport master (
    output play, stop, song_sel, rom_data,
    input  rom_addr, note, playing, song_done
  );

  modport slave (
    input  play, stop, song_sel, rom_data,
    output rom_addr, note, playing, song_done
  );

endinterface

// File: rtl/music_tick_cnt.sv
// Note-period tick counter with synchronous clear and hold, plus decoded
// load/mute/end markers for the sequencer FSM.
module music_tick_cnt #(
  parameter int NOTE_TICKS  = 120000,
  parameter int SOUND_TICKS = 96000,
  parameter int CNT_W       = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_load_o,
  output logic             at_mute_o,
  output logic             at_end_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_o     = cnt_q;
  assign at_load_o = (cnt_q == '0);
  assign at_mute_o = (cnt_q == CNT_W'(SOUND_TICKS));
  assign at_end_o  = (cnt_q == CNT_W'(NOTE_TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_end_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// Note-timing sequencer: walks the music ROM one address per note period and
// emits the registered note code with a silent articulation gap per period.
module music_sequencer
  import music_pkg::*;
#(
  parameter int NOTE_TICKS  = 120000,
  parameter int SOUND_TICKS = 96000,
  parameter int CNT_W       = 24,
  parameter int S0_START    = music_pkg::S0_START,
  parameter int S0_END      = music_pkg::S0_END,
  parameter int S1_START    = music_pkg::S1_START,
  parameter int S1_END      = music_pkg::S1_END
) (
  input  logic             clk,
  input  logic             rst_n,
  music_sequencer_if.slave bus
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              song_q, song_d;
  logic              playing_q;
  logic              done_q, done_d;

  logic              cnt_en, cnt_clr;
  logic [CNT_W-1:0]  cnt;
  logic              at_load, at_mute, at_end;

  function automatic logic [ADDR_W-1:0] song_start(input logic sel);
    return sel ? ADDR_W'(S1_START) : ADDR_W'(S0_START);
  endfunction

  function automatic logic [ADDR_W-1:0] song_end(input logic sel);
    return sel ? ADDR_W'(S1_END) : ADDR_W'(S0_END);
  endfunction

  music_tick_cnt #(
    .NOTE_TICKS (NOTE_TICKS),
    .SOUND_TICKS(SOUND_TICKS),
    .CNT_W      (CNT_W)
  ) u_tick_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (cnt_en),
    .clr_i    (cnt_clr),
    .cnt_o    (cnt),
    .at_load_o(at_load),
    .at_mute_o(at_mute),
    .at_end_o (at_end)
  );

  assign bus.rom_addr  = addr_q;
  assign bus.note      = note_q;
  assign bus.playing   = playing_q;
  assign bus.song_done = done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    song_d  = song_q;
    done_d  = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;

    if (bus.stop) begin
      state_d = IDLE;
      note_d  = '0;
      cnt_clr = 1'b1;
      addr_d  = song_start(bus.song_sel);
      song_d  = bus.song_sel;
    end else begin
      case (state_q)
        IDLE: begin
          addr_d  = song_start(bus.song_sel);
          song_d  = bus.song_sel;
          note_d  = '0;
          cnt_clr = 1'b1;
          if (bus.play) begin
            state_d = PLAY;
          end
        end

        PLAY: begin
          cnt_en = 1'b1;
          if (at_load) begin
            note_d = bus.rom_data;
          end
          if (at_mute) begin
            note_d = '0;
          end
          // The boundary completes even on the edge where play falls.
          if (at_end) begin
            if (bus.song_sel != song_q) begin
              addr_d = song_start(bus.song_sel);
              song_d = bus.song_sel;
            end else if (addr_q == song_end(song_q)) begin
              addr_d = song_start(song_q);
              done_d = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
          if (!bus.play) begin
            state_d = PAUSE;
            note_d  = '0;
          end
        end

        PAUSE: begin
          if (bus.play) begin
            state_d = PLAY;
            // Resuming inside the sounding window restores the note for its remainder.
            if ((cnt != '0) && (cnt <= CNT_W'(SOUND_TICKS))) begin
              note_d = bus.rom_data;
            end
          end
        end

        default: begin
          state_d = IDLE;
          note_d  = '0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= ADDR_W'(S0_START);
      note_q    <= '0;
      song_q    <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      note_q    <= note_d;
      song_q    <= song_d;
      playing_q <= (state_d == PLAY);
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with short note periods and a ROM whose
// data is address+1, covering looping, song change, pause/resume, stop and reset.
module tb_music_sequencer;
  import music_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  music_sequencer_if bus ();

  assign bus.rom_data = 5'(bus.rom_addr + 8'd1);

  music_sequencer #(
    .NOTE_TICKS (10),
    .SOUND_TICKS(8),
    .CNT_W      (4),
    .S0_START   (0),
    .S0_END     (3),
    .S1_START   (4),
    .S1_END     (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.play     = 1'b0;
    bus.stop     = 1'b0;
    bus.song_sel = 1'b0;
    tick();
    tick();
    checks++; if (bus.rom_addr !== 8'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", bus.rom_addr); end
    checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL reset_note: got %0d want 0", bus.note); end
    checks++; if (bus.playing !== 1'b0) begin errors++; $display("[TB] FAIL reset_playing: got %b want 0", bus.playing); end
    checks++; if (bus.song_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.song_done); end
  endtask

  task automatic test_song0_loop();
    logic [7:0] aTab [5];
    logic [7:0] nTab [5];
    logic [7:0] expAddr;
    logic [4:0] expNote;
    logic       expDone;
    aTab = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    nTab = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    rst_n    = 1'b1;
    bus.play = 1'b1;
    tick();
    checks++; if (bus.playing !== 1'b1) begin errors++; $display("[TB] FAIL start_playing: got %b want 1", bus.playing); end
    checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL start_note: got %0d want 0", bus.note); end
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 10; k++) begin
        tick();
        expNote = (k < 8) ? (aTab[p][4:0] + 5'd1) : 5'd0;
        expAddr = (k == 9) ? nTab[p] : aTab[p];
        expDone = (k == 9) && (p == 3);
        checks++; if (bus.note !== expNote) begin errors++; $display("[TB] FAIL s0_note p%0d k%0d: got %0d want %0d", p, k, bus.note, expNote); end
        checks++; if (bus.rom_addr !== expAddr) begin errors++; $display("[TB] FAIL s0_addr p%0d k%0d: got %0d want %0d", p, k, bus.rom_addr, expAddr); end
        checks++; if (bus.song_done !== expDone) begin errors++; $display("[TB] FAIL s0_done p%0d k%0d: got %b want %b", p, k, bus.song_done, expDone); end
      end
    end
  endtask

  task automatic test_song_change();
    logic [7:0] aTab [5];
    logic [7:0] nTab [5];
    logic [7:0] expAddr;
    logic [4:0] expNote;
    logic       expDone;
    aTab = '{8'd1, 8'd4, 8'd5, 8'd6, 8'd4};
    nTab = '{8'd4, 8'd5, 8'd6, 8'd4, 8'd5};
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 10; k++) begin
        tick();
        expNote = (k < 8) ? (aTab[p][4:0] + 5'd1) : 5'd0;
        expAddr = (k == 9) ? nTab[p] : aTab[p];
        expDone = (k == 9) && (p == 3);
        checks++; if (bus.note !== expNote) begin errors++; $display("[TB] FAIL chg_note p%0d k%0d: got %0d want %0d", p, k, bus.note, expNote); end
        checks++; if (bus.rom_addr !== expAddr) begin errors++; $display("[TB] FAIL chg_addr p%0d k%0d: got %0d want %0d", p, k, bus.rom_addr, expAddr); end
        checks++; if (bus.song_done !== expDone) begin errors++; $display("[TB] FAIL chg_done p%0d k%0d: got %b want %b", p, k, bus.song_done, expDone); end
        if (p == 0 && k == 3) bus.song_sel = 1'b1;
      end
    end
  endtask

  task automatic test_pause_resume();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.note !== 5'd6) begin errors++; $display("[TB] FAIL pre_pause_note k%0d: got %0d want 6", k, bus.note); end
    end
    bus.play = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL pause_note k%0d: got %0d want 0", k, bus.note); end
      checks++; if (bus.playing !== 1'b0) begin errors++; $display("[TB] FAIL pause_playing k%0d: got %b want 0", k, bus.playing); end
      checks++; if (bus.rom_addr !== 8'd5) begin errors++; $display("[TB] FAIL pause_addr k%0d: got %0d want 5", k, bus.rom_addr); end
    end
    bus.play = 1'b1;
    tick();
    checks++; if (bus.playing !== 1'b1) begin errors++; $display("[TB] FAIL resume_playing: got %b want 1", bus.playing); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      checks++; if (bus.note !== 5'd6) begin errors++; $display("[TB] FAIL resume_note k%0d: got %0d want 6", k, bus.note); end
    end
    tick();
    checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL resume_gap_note: got %0d want 0", bus.note); end
    checks++; if (bus.rom_addr !== 8'd5) begin errors++; $display("[TB] FAIL resume_gap_addr: got %0d want 5", bus.rom_addr); end
    tick();
    checks++; if (bus.rom_addr !== 8'd6) begin errors++; $display("[TB] FAIL resume_next_addr: got %0d want 6", bus.rom_addr); end
    checks++; if (bus.song_done !== 1'b0) begin errors++; $display("[TB] FAIL resume_done: got %b want 0", bus.song_done); end
    tick();
    checks++; if (bus.note !== 5'd7) begin errors++; $display("[TB] FAIL resume_next_note: got %0d want 7", bus.note); end
  endtask

  task automatic test_pause_on_boundary();
    repeat (8) tick();
    checks++; if (bus.rom_addr !== 8'd6) begin errors++; $display("[TB] FAIL pb_pre_addr: got %0d want 6", bus.rom_addr); end
    tick();
    checks++; if (bus.rom_addr !== 8'd4) begin errors++; $display("[TB] FAIL pb_wrap_addr: got %0d want 4", bus.rom_addr); end
    checks++; if (bus.song_done !== 1'b1) begin errors++; $display("[TB] FAIL pb_wrap_done: got %b want 1", bus.song_done); end
    repeat (9) tick();
    checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL pb_gap_note: got %0d want 0", bus.note); end
    checks++; if (bus.rom_addr !== 8'd4) begin errors++; $display("[TB] FAIL pb_gap_addr: got %0d want 4", bus.rom_addr); end
    bus.play = 1'b0;
    tick();
    checks++; if (bus.rom_addr !== 8'd5) begin errors++; $display("[TB] FAIL pb_edge_addr: got %0d want 5", bus.rom_addr); end
    checks++; if (bus.playing !== 1'b0) begin errors++; $display("[TB] FAIL pb_edge_playing: got %b want 0", bus.playing); end
    checks++; if (bus.song_done !== 1'b0) begin errors++; $display("[TB] FAIL pb_edge_done: got %b want 0", bus.song_done); end
    repeat (3) tick();
    checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL pb_hold_note: got %0d want 0", bus.note); end
    checks++; if (bus.rom_addr !== 8'd5) begin errors++; $display("[TB] FAIL pb_hold_addr: got %0d want 5", bus.rom_addr); end
    bus.play = 1'b1;
    tick();
    checks++; if (bus.playing !== 1'b1) begin errors++; $display("[TB] FAIL pb_resume_playing: got %b want 1", bus.playing); end
    checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL pb_resume_note: got %0d want 0", bus.note); end
    tick();
    checks++; if (bus.note !== 5'd6) begin errors++; $display("[TB] FAIL pb_load_note: got %0d want 6", bus.note); end
  endtask

  task automatic test_stop();
    repeat (2) tick();
    checks++; if (bus.note !== 5'd6) begin errors++; $display("[TB] FAIL stop_pre_note: got %0d want 6", bus.note); end
    bus.stop = 1'b1;
    bus.play = 1'b0;
    tick();
    bus.stop = 1'b0;
    checks++; if (bus.playing !== 1'b0) begin errors++; $display("[TB] FAIL stop_playing: got %b want 0", bus.playing); end
    checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL stop_note: got %0d want 0", bus.note); end
    checks++; if (bus.rom_addr !== 8'd4) begin errors++; $display("[TB] FAIL stop_addr: got %0d want 4", bus.rom_addr); end
    bus.song_sel = 1'b0;
    tick();
    checks++; if (bus.rom_addr !== 8'd0) begin errors++; $display("[TB] FAIL idle_follow0: got %0d want 0", bus.rom_addr); end
    checks++; if (bus.playing !== 1'b0) begin errors++; $display("[TB] FAIL idle_playing: got %b want 0", bus.playing); end
    bus.song_sel = 1'b1;
    tick();
    checks++; if (bus.rom_addr !== 8'd4) begin errors++; $display("[TB] FAIL idle_follow1: got %0d want 4", bus.rom_addr); end
    bus.play = 1'b1;
    tick();
    checks++; if (bus.playing !== 1'b1) begin errors++; $display("[TB] FAIL restart_playing: got %b want 1", bus.playing); end
    checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL restart_first_note: got %0d want 0", bus.note); end
    tick();
    checks++; if (bus.note !== 5'd5) begin errors++; $display("[TB] FAIL restart_note: got %0d want 5", bus.note); end
    checks++; if (bus.rom_addr !== 8'd4) begin errors++; $display("[TB] FAIL restart_addr: got %0d want 4", bus.rom_addr); end
  endtask

  task automatic test_async_reset();
    bus.song_sel = 1'b0;
    repeat (8) tick();
    tick();
    checks++; if (bus.rom_addr !== 8'd0) begin errors++; $display("[TB] FAIL ar_switch_addr: got %0d want 0", bus.rom_addr); end
    checks++; if (bus.song_done !== 1'b0) begin errors++; $display("[TB] FAIL ar_switch_done: got %b want 0", bus.song_done); end
    repeat (20) tick();
    repeat (5) tick();
    checks++; if (bus.rom_addr !== 8'd2) begin errors++; $display("[TB] FAIL ar_pre_addr: got %0d want 2", bus.rom_addr); end
    checks++; if (bus.note !== 5'd3) begin errors++; $display("[TB] FAIL ar_pre_note: got %0d want 3", bus.note); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL ar_note: got %0d want 0", bus.note); end
    checks++; if (bus.rom_addr !== 8'd0) begin errors++; $display("[TB] FAIL ar_addr: got %0d want 0", bus.rom_addr); end
    checks++; if (bus.playing !== 1'b0) begin errors++; $display("[TB] FAIL ar_playing: got %b want 0", bus.playing); end
    checks++; if (bus.song_done !== 1'b0) begin errors++; $display("[TB] FAIL ar_done: got %b want 0", bus.song_done); end
    tick();
    tick();
    bus.play = 1'b0;
    rst_n    = 1'b1;
    tick();
    checks++; if (bus.playing !== 1'b0) begin errors++; $display("[TB] FAIL post_ar_playing: got %b want 0", bus.playing); end
    checks++; if (bus.note !== 5'd0) begin errors++; $display("[TB] FAIL post_ar_note: got %0d want 0", bus.note); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_song0_loop();
    test_song_change();
    test_pause_resume();
    test_pause_on_boundary();
    test_stop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
